// File: rtl/pe_mem_namespace_if.sv
// Port bundle for the per-PE local storage block: instruction FIFO
// handshake plus the four single-write/single-read memory ports.
interface pe_mem_namespace_if #(
  parameter int INST_ADDR_LEN   = 6,
  parameter int DATA_ADDR_LEN   = 6,
  parameter int WEIGHT_ADDR_LEN = 6,
  parameter int META_ADDR_LEN   = 2,
  parameter int DATA_LEN        = 32,
  parameter int INST_LEN        = 32
) ();

  // Instruction FIFO
  logic                       inst_wrt;
  logic [INST_LEN-1:0]        inst_in;
  logic                       inst_fifo_full;
  logic                       inst_stall;
  logic [INST_LEN-1:0]        inst_out;
  logic                       inst_valid;

  // Data memory
  logic                       data_wrt;
  logic [DATA_ADDR_LEN-1:0]   data_wrt_addr;
  logic [DATA_ADDR_LEN-1:0]   data_rd_addr;
  logic [DATA_LEN-1:0]        data_in;
  logic [DATA_LEN-1:0]        data_out;

  // Weight memory
  logic                       weight_wrt;
  logic [WEIGHT_ADDR_LEN-1:0] weight_wrt_addr;
  logic [WEIGHT_ADDR_LEN-1:0] weight_rd_addr;
  logic [DATA_LEN-1:0]        weight_in;
  logic [DATA_LEN-1:0]        weight_out;

  // Gradient memory (same geometry as weight)
  logic                       gradient_wrt;
  logic [WEIGHT_ADDR_LEN-1:0] gradient_wrt_addr;
  logic [WEIGHT_ADDR_LEN-1:0] gradient_rd_addr;
  logic [DATA_LEN-1:0]        gradient_in;
  logic [DATA_LEN-1:0]        gradient_out;

  // Meta memory
  logic                       meta_wrt;
  logic [META_ADDR_LEN-1:0]   meta_wrt_addr;
  logic [META_ADDR_LEN-1:0]   meta_rd_addr;
  logic [DATA_LEN-1:0]        meta_in;
  logic [DATA_LEN-1:0]        meta_out;

  // Producer side: load path / decoder driving the block
  modport master (
    output inst_wrt, inst_in, inst_stall,
    output data_wrt, data_wrt_addr, data_rd_addr, data_in,
    output weight_wrt, weight_wrt_addr, weight_rd_addr, weight_in,
    output gradient_wrt, gradient_wrt_addr, gradient_rd_addr, gradient_in,
    output meta_wrt, meta_wrt_addr, meta_rd_addr, meta_in,
    input  inst_fifo_full, inst_out, inst_valid,
    input  data_out, weight_out, gradient_out, meta_out
  );

  // Storage block side
  modport slave (
    input  inst_wrt, inst_in, inst_stall,
    input  data_wrt, data_wrt_addr, data_rd_addr, data_in,
    input  weight_wrt, weight_wrt_addr, weight_rd_addr, weight_in,
    input  gradient_wrt, gradient_wrt_addr, gradient_rd_addr, gradient_in,
    input  meta_wrt, meta_wrt_addr, meta_rd_addr, meta_in,
    output inst_fifo_full, inst_out, inst_valid,
    output data_out, weight_out, gradient_out, meta_out
  );

endinterface

// File: rtl/pe_mem_namespace.sv
// Per-PE local storage: instruction FIFO feeding the decoder under a
// stall handshake, plus data/weight/gradient/meta memories with
// synchronous read-first reads. Everything runs in parallel.

// Single-write/single-read memory bank, latency-1 read-first output.
module pe_mem_bank #(
  parameter int ADDR_LEN = 6,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wrt,
  input  logic [ADDR_LEN-1:0] wrt_addr,
  input  logic [ADDR_LEN-1:0] rd_addr,
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout
);

  logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

  // Storage array write; reset blocks writes but never clears contents.
  // NOTE: the array has no reset branch on purpose -- clearing it would
  // forbid RAM inference and the contents are defined only once written.
  always_ff @(posedge clk) begin
    if (!reset && wrt) mem[wrt_addr] <= din;
  end

  // Registered read port; same-address write in this cycle returns old data.
  // NOTE: non-blocking assignment makes the read see the pre-edge contents,
  // which is exactly the read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) dout <= '0;
    else       dout <= mem[rd_addr];
  end

endmodule

module pe_mem_namespace #(
  parameter int INST_ADDR_LEN   = 6,
  parameter int DATA_ADDR_LEN   = 6,
  parameter int WEIGHT_ADDR_LEN = 6,
  parameter int META_ADDR_LEN   = 2,
  parameter int DATA_LEN        = 32,
  parameter int INST_LEN        = 32
) (
  input logic               clk,
  input logic               reset,
  pe_mem_namespace_if.slave bus
);

  localparam logic [INST_ADDR_LEN:0] DEPTH = (INST_ADDR_LEN+1)'(1 << INST_ADDR_LEN);

  // ---------------- Instruction FIFO ----------------
  logic [INST_LEN-1:0]      fifo_mem [2**INST_ADDR_LEN];
  logic [INST_ADDR_LEN-1:0] wr_ptr;
  logic [INST_ADDR_LEN-1:0] rd_ptr;
  logic [INST_ADDR_LEN:0]   count;
  logic [INST_ADDR_LEN:0]   count_next;
  logic                     push_ok;
  logic                     pop_ok;

  // Push/pop qualification and next occupancy; full is judged on the
  // pre-edge count, so a push to a full FIFO is dropped even when a pop
  // frees a slot in the same cycle.
  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    count_next = count;
    push_ok    = !reset && bus.inst_wrt && (count != DEPTH);
    pop_ok     = !reset && !bus.inst_stall && (count != '0);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO storage write at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.inst_in;
  end

  // Pointers, occupancy, full flag and the registered issue port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.inst_fifo_full <= 1'b0;
      bus.inst_out       <= '0;
      bus.inst_valid     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr         <= rd_ptr + 1'b1;
        bus.inst_out   <= fifo_mem[rd_ptr];
        bus.inst_valid <= 1'b1;
      end else if (!bus.inst_stall) begin
        // Unstalled but empty: nothing new issued, inst_out keeps its value.
        bus.inst_valid <= 1'b0;
      end
      count              <= count_next;
      bus.inst_fifo_full <= (count_next == DEPTH);
    end
  end

  // ---------------- Operand memories ----------------
  pe_mem_bank #(.ADDR_LEN(DATA_ADDR_LEN), .DATA_LEN(DATA_LEN)) u_data (
    .clk      (clk),
    .reset    (reset),
    .wrt      (bus.data_wrt),
    .wrt_addr (bus.data_wrt_addr),
    .rd_addr  (bus.data_rd_addr),
    .din      (bus.data_in),
    .dout     (bus.data_out)
  );

  pe_mem_bank #(.ADDR_LEN(WEIGHT_ADDR_LEN), .DATA_LEN(DATA_LEN)) u_weight (
    .clk      (clk),
    .reset    (reset),
    .wrt      (bus.weight_wrt),
    .wrt_addr (bus.weight_wrt_addr),
    .rd_addr  (bus.weight_rd_addr),
    .din      (bus.weight_in),
    .dout     (bus.weight_out)
  );

  pe_mem_bank #(.ADDR_LEN(WEIGHT_ADDR_LEN), .DATA_LEN(DATA_LEN)) u_gradient (
    .clk      (clk),
    .reset    (reset),
    .wrt      (bus.gradient_wrt),
    .wrt_addr (bus.gradient_wrt_addr),
    .rd_addr  (bus.gradient_rd_addr),
    .din      (bus.gradient_in),
    .dout     (bus.gradient_out)
  );

  pe_mem_bank #(.ADDR_LEN(META_ADDR_LEN), .DATA_LEN(DATA_LEN)) u_meta (
    .clk      (clk),
    .reset    (reset),
    .wrt      (bus.meta_wrt),
    .wrt_addr (bus.meta_wrt_addr),
    .rd_addr  (bus.meta_rd_addr),
    .din      (bus.meta_in),
    .dout     (bus.meta_out)
  );

endmodule

// File: tb/tb_pe_mem_namespace.sv
// Directed bench for pe_mem_namespace: FIFO ordering, stall, full/drop,
// mid-stream reset, memory read latency and read-first collisions.
module tb_pe_mem_namespace;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pe_mem_namespace_if bus ();

  pe_mem_namespace dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] fill_val [64];
    checks   = 0;
    failures = 0;

    reset                 = 1'b1;
    bus.inst_wrt          = 1'b0;
    bus.inst_in           = '0;
    bus.inst_stall        = 1'b0;
    bus.data_wrt          = 1'b0;
    bus.data_wrt_addr     = '0;
    bus.data_rd_addr      = '0;
    bus.data_in           = '0;
    bus.weight_wrt        = 1'b0;
    bus.weight_wrt_addr   = '0;
    bus.weight_rd_addr    = '0;
    bus.weight_in         = '0;
    bus.gradient_wrt      = 1'b0;
    bus.gradient_wrt_addr = '0;
    bus.gradient_rd_addr  = '0;
    bus.gradient_in       = '0;
    bus.meta_wrt          = 1'b0;
    bus.meta_wrt_addr     = '0;
    bus.meta_rd_addr      = '0;
    bus.meta_in           = '0;

    // ---- reset state ----
    step();
    step();
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_out", bus.inst_out, 32'd0);
    check("rst_full", {31'd0, bus.inst_fifo_full}, 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_meta_out", bus.meta_out, 32'd0);
    reset = 1'b0;

    // ---- push 3, 321, 723 with no stall ----
    bus.inst_wrt = 1'b1;
    bus.inst_in  = 32'd3;
    step();
    check("no_bypass_valid", {31'd0, bus.inst_valid}, 32'd0);
    bus.inst_in = 32'd321;
    step();
    check("pop0_out", bus.inst_out, 32'd3);
    check("pop0_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.inst_in = 32'd723;
    step();
    check("pop1_out", bus.inst_out, 32'd321);
    check("pop1_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.inst_wrt = 1'b0;
    step();
    check("pop2_out", bus.inst_out, 32'd723);
    check("pop2_valid", {31'd0, bus.inst_valid}, 32'd1);
    step();
    check("empty_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("empty_out_hold", bus.inst_out, 32'd723);

    // ---- push 723 under a 5-cycle stall ----
    bus.inst_stall = 1'b1;
    bus.inst_wrt   = 1'b1;
    bus.inst_in    = 32'd723;
    step();
    bus.inst_wrt = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stall_valid_frozen", {31'd0, bus.inst_valid}, 32'd0);
    check("stall_out_frozen", bus.inst_out, 32'd723);
    bus.inst_stall = 1'b0;
    step();
    check("unstall_out", bus.inst_out, 32'd723);
    check("unstall_valid", {31'd0, bus.inst_valid}, 32'd1);
    step();
    check("unstall_drain_valid", {31'd0, bus.inst_valid}, 32'd0);

    // ---- fill 64 under stall, overflow push, then drain ----
    bus.inst_stall = 1'b1;
    bus.inst_wrt   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fill_val[i] = 32'd100 + 32'(i) * 32'd7;
      bus.inst_in = fill_val[i];
      step();
      if (i == 62) check("full_at_63", {31'd0, bus.inst_fifo_full}, 32'd0);
    end
    check("full_at_64", {31'd0, bus.inst_fifo_full}, 32'd1);
    check("stall_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
    bus.inst_in = 32'd9999;
    step();
    check("full_after_drop", {31'd0, bus.inst_fifo_full}, 32'd1);
    // First pop with a simultaneous push: the push must be dropped.
    bus.inst_stall = 1'b0;
    bus.inst_in    = 32'd5555;
    step();
    bus.inst_wrt = 1'b0;
    check("drain0_out", bus.inst_out, fill_val[0]);
    check("drain0_full", {31'd0, bus.inst_fifo_full}, 32'd0);
    for (int i = 1; i < 64; i++) begin
      step();
      check($sformatf("drain%0d_out", i), bus.inst_out, fill_val[i]);
      check($sformatf("drain%0d_valid", i), {31'd0, bus.inst_valid}, 32'd1);
    end
    step();
    check("drained_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("drained_out_hold", bus.inst_out, fill_val[63]);

    // ---- reset with 2 entries queued; push during reset is blocked ----
    bus.inst_stall = 1'b1;
    bus.inst_wrt   = 1'b1;
    bus.inst_in    = 32'd11;
    step();
    bus.inst_in = 32'd22;
    step();
    reset       = 1'b1;
    bus.inst_in = 32'd33;
    step();
    check("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("midrst_out", bus.inst_out, 32'd0);
    check("midrst_full", {31'd0, bus.inst_fifo_full}, 32'd0);
    reset          = 1'b0;
    bus.inst_wrt   = 1'b0;
    bus.inst_stall = 1'b0;
    step();
    check("midrst_nopop1_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    check("midrst_nopop2_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("midrst_nopop2_out", bus.inst_out, 32'd0);

    // ---- memory writes then reads one cycle later ----
    bus.data_wrt          = 1'b1;
    bus.data_wrt_addr     = 6'd6;
    bus.data_in           = 32'd10;
    bus.weight_wrt        = 1'b1;
    bus.weight_wrt_addr   = 6'd21;
    bus.weight_in         = 32'd212;
    bus.gradient_wrt      = 1'b1;
    bus.gradient_wrt_addr = 6'd30;
    bus.gradient_in       = 32'd3222;
    bus.meta_wrt          = 1'b1;
    bus.meta_wrt_addr     = 2'd1;
    bus.meta_in           = 32'd13;
    step();
    bus.data_wrt_addr     = 6'd7;
    bus.data_in           = 32'd55;
    bus.weight_wrt        = 1'b0;
    bus.gradient_wrt      = 1'b0;
    bus.meta_wrt          = 1'b0;
    bus.data_rd_addr      = 6'd6;
    bus.weight_rd_addr    = 6'd21;
    bus.gradient_rd_addr  = 6'd30;
    bus.meta_rd_addr      = 2'd1;
    step();
    bus.data_wrt = 1'b0;
    check("data_rd6", bus.data_out, 32'd10);
    check("weight_rd21", bus.weight_out, 32'd212);
    check("gradient_rd30", bus.gradient_out, 32'd3222);
    check("meta_rd1", bus.meta_out, 32'd13);
    bus.data_rd_addr = 6'd7;
    step();
    check("data_rd7", bus.data_out, 32'd55);

    // ---- read-first collision at addr 6 ----
    bus.data_wrt      = 1'b1;
    bus.data_wrt_addr = 6'd6;
    bus.data_in       = 32'd99;
    bus.data_rd_addr  = 6'd6;
    step();
    bus.data_wrt = 1'b0;
    check("rf_old", bus.data_out, 32'd10);
    step();
    check("rf_new", bus.data_out, 32'd99);

    // ---- reset clears outputs, keeps contents, blocks writes ----
    reset         = 1'b1;
    bus.data_wrt  = 1'b1;
    bus.data_in   = 32'd1234;
    step();
    check("memrst_data_out", bus.data_out, 32'd0);
    check("memrst_weight_out", bus.weight_out, 32'd0);
    reset        = 1'b0;
    bus.data_wrt = 1'b0;
    step();
    check("memrst_kept_data", bus.data_out, 32'd99);
    check("memrst_kept_weight", bus.weight_out, 32'd212);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
